// File: rtl/traffic_sequencer_pkg.sv
// Shared types for the traffic light sequencer and its output driver.
// Holds the light-state encoding and the timer width helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        MAIN_GREEN  = 2'b00,
        MAIN_YELLOW = 2'b01,
        SIDE_GREEN  = 2'b10,
        SIDE_YELLOW = 2'b11
    } state_t;

    // Timer width able to hold the longest interval count.
    function automatic int calc_tw(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// Control/status bundle between the sequencer and its environment.
// master drives tick/en/side_req; slave is the sequencer.
interface traffic_sequencer_if #(
    parameter int TW = 4
);
    import traffic_pkg::*;

    logic          tick;
    logic          en;
    logic          side_req;
    state_t        state;
    logic [TW-1:0] remaining;
    logic          req_pending;
    logic          state_chg;

    modport master (
        output tick,
        output en,
        output side_req,
        input  state,
        input  remaining,
        input  req_pending,
        input  state_chg
    );

    modport slave (
        input  tick,
        input  en,
        input  side_req,
        output state,
        output remaining,
        output req_pending,
        output state_chg
    );

endinterface

// File: rtl/traffic_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Adds two cycles of latency; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/traffic_sequencer.sv
// Tick-timed main/side road light sequencer.
// Main rests green; a latched side request runs one side phase.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int MAIN_MIN_T = 8,
    parameter int YELLOW_T   = 3,
    parameter int SIDE_T     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    traffic_sequencer_if.slave  bus
);

    localparam int TW = calc_tw(MAIN_MIN_T, YELLOW_T, SIDE_T);

    localparam logic [TW-1:0] MG_LAST = TW'(MAIN_MIN_T - 1);
    localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] S_LAST  = TW'(SIDE_T - 1);

    if (MAIN_MIN_T < 1) begin : g_bad_main
        $error("MAIN_MIN_T must be >= 1");
    end
    if (YELLOW_T < 1) begin : g_bad_yellow
        $error("YELLOW_T must be >= 1");
    end
    if (SIDE_T < 1) begin : g_bad_side
        $error("SIDE_T must be >= 1");
    end

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_q, req_d;
    logic          trans_q, trans_d;
    logic          chg_q;
    logic          req_sync;
    logic          adv;
    logic [TW-1:0] rem;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.side_req),
        .q_o   (req_sync)
    );

    assign adv = bus.tick && bus.en;

    // Next state, timer and request latch; clear on side-green entry wins.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        req_d   = req_q;
        trans_d = 1'b0;

        if (bus.en && req_sync &&
            (state_q == MAIN_GREEN || state_q == MAIN_YELLOW)) begin
            req_d = 1'b1;
        end

        if (adv) begin
            case (state_q)
                MAIN_GREEN: begin
                    if (timer_q == MG_LAST) begin
                        if (req_q) state_d = MAIN_YELLOW;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                MAIN_YELLOW: begin
                    if (timer_q == Y_LAST) state_d = SIDE_GREEN;
                    else timer_d = timer_q + 1'b1;
                end
                SIDE_GREEN: begin
                    if (timer_q == S_LAST) state_d = SIDE_YELLOW;
                    else timer_d = timer_q + 1'b1;
                end
                SIDE_YELLOW: begin
                    if (timer_q == Y_LAST) state_d = MAIN_GREEN;
                    else timer_d = timer_q + 1'b1;
                end
                default: state_d = MAIN_GREEN;
            endcase
        end

        if (state_d != state_q) begin
            timer_d = '0;
            trans_d = 1'b1;
            if (state_d == SIDE_GREEN) req_d = 1'b0;
        end
    end

    // Ticks left in the current interval; 0 while main green waits.
    always_comb begin
        rem = '0;
        case (state_q)
            MAIN_GREEN:  rem = MG_LAST - timer_q;
            MAIN_YELLOW: rem = Y_LAST - timer_q;
            SIDE_GREEN:  rem = S_LAST - timer_q;
            SIDE_YELLOW: rem = Y_LAST - timer_q;
            default:     rem = '0;
        endcase
    end

    // Sequencer registers; state_chg trails the transition by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MAIN_GREEN;
            timer_q <= '0;
            req_q   <= 1'b0;
            trans_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            trans_q <= trans_d;
            chg_q   <= trans_q;
        end
    end

    assign bus.state       = state_q;
    assign bus.remaining   = rem;
    assign bus.req_pending = req_q;
    assign bus.state_chg   = chg_q;

endmodule
